fc_apu_resp_buffer: RTL and testbench
=====================================

Name: fc_apu_resp_buffer

Overview:
- Sits between the FC core's APU port and the FPU wrapper.
- Gates FPU request acceptance with an outstanding-operation credit counter.
- Buffers FPU results, which arrive with no back-pressure, in a small FIFO, then presents them to the core with a valid/ready handshake.
- Guarantees no FPU result is ever dropped, even when the core stalls writeback.

Parameters:
- DEPTH, 4, response FIFO entries and maximum outstanding FPU operations (legal range 2..16).
- DATA_W, 32, result data width.
- FLAGS_W, 5, status flag width (matches APU_NUSFLAGS_CPU).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- core_req_i  in  1  core requests an FPU operation.
- core_gnt_o  out  1  operation accepted.
- fpu_req_o  out  1  request forwarded to the FPU wrapper.
- fpu_gnt_i  in  1  FPU wrapper ready.
- fpu_rvalid_i  in  1  FPU result valid (single-cycle pulse, cannot be stalled).
- fpu_rdata_i  in  DATA_W  FPU result.
- fpu_rflags_i  in  FLAGS_W  FPU status flags.
- core_rvalid_o  out  1  buffered result available.
- core_rready_i  in  1  core consumes the result.
- core_rdata_o  out  DATA_W  result to core.
- core_rflags_o  out  FLAGS_W  flags to core.
- outstanding_o  out  $clog2(DEPTH+1)  current credit usage.
- overflow_o  out  1  sticky error: push while the FIFO is full.

Behaviour:
- Clock and reset: single clock clk_i; reset rst_ni is asynchronous, active-low.
- Reset values: all outputs 0; FIFO empty; counter 0; overflow_o 0.
- credit_ok = (outstanding < DEPTH).
- Request gating (combinational): fpu_req_o = core_req_i & credit_ok; core_gnt_o = fpu_gnt_i & credit_ok.
- Issue event: fpu_req_o & fpu_gnt_i.
- Retire event: core_rvalid_o & core_rready_i.
- outstanding counter:
  - +1 on issue only.
  - −1 on retire only.
  - Unchanged when both or neither occur in the same cycle.
  - Never wraps. Issue at DEPTH is impossible by gating. Retire at 0 is impossible because the FIFO is empty.
- FIFO:
  - Push {fpu_rdata_i, fpu_rflags_i} on fpu_rvalid_i.
  - Pop on retire.
  - Head drives core_rdata_o/core_rflags_o; core_rvalid_o = !empty.
  - Registered, so a result becomes visible to the core the cycle after fpu_rvalid_i.
  - Push and pop in the same cycle are legal at any occupancy, including full: occupancy is unchanged and the head advances.
  - Read/write pointers wrap modulo DEPTH. Full/empty are derived from an occupancy count of width $clog2(DEPTH+1).
- Overflow: push while full without a simultaneous pop sets overflow_o (sticky until reset) and discards the incoming data. By construction this only happens if the FPU returns a result that was never issued.
- Data stability: while core_rvalid_o=1 and core_rready_i=0, core_rdata_o/core_rflags_o are held stable.
- Reset mid-operation: in-flight FPU results are forgotten and the counter returns to 0. The FPU wrapper is reset on the same rst_ni.

Optional Feature:
- Macro: FC_APU_RESP_BYPASS_EN.
- Defined:
  - When the FIFO is empty and fpu_rvalid_i=1, the result drives core_rvalid_o/core_rdata_o/core_rflags_o combinationally in the same cycle.
  - If core_rready_i=1 that cycle, the result retires without being written to the FIFO; otherwise it is pushed.
  - Latency 0.
- Undefined: always pushed; latency 1.
- Credit accounting is identical in both builds.

Decomposition:
- Package fc_apu_buf_pkg:
  - resp_t packed struct {rdata[DATA_W-1:0], rflags[FLAGS_W-1:0]}.
  - Default DEPTH constant.
- Sub-module fc_apu_resp_fifo:
  - Generic DEPTH-entry FIFO of resp_t.
  - Ports: push, pop, full, empty, count.
- The top level holds the credit counter, gating, bypass mux and overflow flag.

Test Plan:
- Reset, then a single op: req with gnt at cycle 1; fpu_rvalid_i at cycle 4 with data 0x3F800000, flags 0x01 -> core_rvalid_o=1 at cycle 5 with that data; outstanding 1 until retire, then 0.
- Credit stall, DEPTH=4, core_rready_i=0: issue 4 ops -> outstanding_o=4, core_gnt_o=0 and fpu_req_o=0 while core_req_i=1. Then pop one -> grant resumes the next cycle.
- Full FIFO with simultaneous push/pop: FIFO holds 4 entries; fpu_rvalid_i and core_rready_i high in the same cycle -> occupancy stays 4, order preserved, overflow_o=0.
- Ordering: 8 results with data 0..7 under random core_rready_i -> retired in order 0..7; outstanding_o ends at 0.
- Overflow: inject fpu_rvalid_i with no issued op while full -> overflow_o=1 and sticky; FIFO contents unchanged.
- Bypass (macro defined): empty FIFO, fpu_rvalid_i with data 0xDEADBEEF and core_rready_i=1 -> core_rvalid_o=1 with 0xDEADBEEF in the same cycle; FIFO stays empty.

Source files
------------

// File: rtl/fc_apu_buf_pkg.sv
// Shared types and defaults for the FC APU response buffer.
package fc_apu_buf_pkg;

    localparam int unsigned DEFAULT_DEPTH   = 4;
    localparam int unsigned DEFAULT_DATA_W  = 32;
    localparam int unsigned DEFAULT_FLAGS_W = 5;

    typedef struct packed {
        logic [DEFAULT_DATA_W-1:0]  rdata;
        logic [DEFAULT_FLAGS_W-1:0] rflags;
    } resp_t;

endpackage

// File: rtl/fc_apu_resp_fifo.sv
// Generic DEPTH-entry FIFO; a push while full is accepted only with a simultaneous pop,
// otherwise it is dropped.
module fc_apu_resp_fifo
    import fc_apu_buf_pkg::*;
#(
    parameter int unsigned DEPTH   = DEFAULT_DEPTH,
    parameter type         entry_t = resp_t
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  entry_t                     wdata_i,
    input  logic                       pop_i,
    output entry_t                     rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               wr_en, rd_en;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign wr_en = push_i && (!full_o || pop_i);
    assign rd_en = pop_i && !empty_o;

    always_comb begin
        count_d = count_q;
        if (wr_en && !rd_en) begin
            count_d = count_q + CNT_W'(1);
        end else if (rd_en && !wr_en) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            if (wr_en) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH-1)) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH-1)) ? '0 : rd_ptr_q + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/fc_apu_resp_buffer.sv
// APU-to-FPU response buffer: credit-gated issue, lossless result FIFO, sticky overflow.
// Define FC_APU_RESP_BYPASS_EN for a zero-latency path when the FIFO is empty.
module fc_apu_resp_buffer
    import fc_apu_buf_pkg::*;
#(
    parameter int unsigned DEPTH   = DEFAULT_DEPTH,
    parameter int unsigned DATA_W  = DEFAULT_DATA_W,
    parameter int unsigned FLAGS_W = DEFAULT_FLAGS_W
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       core_req_i,
    output logic                       core_gnt_o,
    output logic                       fpu_req_o,
    input  logic                       fpu_gnt_i,
    input  logic                       fpu_rvalid_i,
    input  logic [DATA_W-1:0]          fpu_rdata_i,
    input  logic [FLAGS_W-1:0]         fpu_rflags_i,
    output logic                       core_rvalid_o,
    input  logic                       core_rready_i,
    output logic [DATA_W-1:0]          core_rdata_o,
    output logic [FLAGS_W-1:0]         core_rflags_o,
    output logic [$clog2(DEPTH+1)-1:0] outstanding_o,
    output logic                       overflow_o
);

    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    typedef struct packed {
        logic [DATA_W-1:0]  rdata;
        logic [FLAGS_W-1:0] rflags;
    } entry_t;

    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic             overflow_q;
    logic             credit_ok, issue, retire;
    logic             bypass, push, pop;
    logic             fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    entry_t           fifo_wdata, fifo_head;

    assign credit_ok  = (outstanding_q < CNT_W'(DEPTH));
    assign fpu_req_o  = core_req_i & credit_ok;
    assign core_gnt_o = fpu_gnt_i & credit_ok;
    assign issue      = fpu_req_o & fpu_gnt_i;

`ifdef FC_APU_RESP_BYPASS_EN
    assign bypass = fifo_empty & fpu_rvalid_i;
`else
    assign bypass = 1'b0;
`endif

    assign core_rvalid_o = !fifo_empty | bypass;
    assign core_rdata_o  = bypass ? fpu_rdata_i  : fifo_head.rdata;
    assign core_rflags_o = bypass ? fpu_rflags_i : fifo_head.rflags;
    assign retire        = core_rvalid_o & core_rready_i;

    // A bypassed result that retires immediately never touches the FIFO.
    assign push       = fpu_rvalid_i & !(bypass & core_rready_i);
    assign pop        = retire & !fifo_empty;
    assign fifo_wdata = '{rdata: fpu_rdata_i, rflags: fpu_rflags_i};

    fc_apu_resp_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .wdata_i (fifo_wdata),
        .pop_i   (pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Decrement holds at zero so a stray unissued result can never wrap the counter.
    always_comb begin
        outstanding_d = outstanding_q;
        if (issue && !retire) begin
            outstanding_d = outstanding_q + CNT_W'(1);
        end else if (retire && !issue && (outstanding_q != '0)) begin
            outstanding_d = outstanding_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_q <= '0;
            overflow_q    <= 1'b0;
        end else begin
            outstanding_q <= outstanding_d;
            if (push && fifo_full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign outstanding_o = outstanding_q;
    assign overflow_o    = overflow_q;

    logic unused_count;
    assign unused_count = ^fifo_count;

endmodule

// File: tb/tb_fc_apu_resp_buffer.sv
// Directed self-checking bench for fc_apu_resp_buffer (DEPTH=4).
module tb_fc_apu_resp_buffer;

    logic        clk;
    logic        rst_n;
    logic        core_req;
    logic        core_gnt;
    logic        fpu_req;
    logic        fpu_gnt;
    logic        fpu_rvalid;
    logic [31:0] fpu_rdata;
    logic [4:0]  fpu_rflags;
    logic        core_rvalid;
    logic        core_rready;
    logic [31:0] core_rdata;
    logic [4:0]  core_rflags;
    logic [2:0]  outstanding;
    logic        overflow;

    int n_vec  = 0;
    int n_fail = 0;

    fc_apu_resp_buffer #(
        .DEPTH   (4),
        .DATA_W  (32),
        .FLAGS_W (5)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .core_req_i    (core_req),
        .core_gnt_o    (core_gnt),
        .fpu_req_o     (fpu_req),
        .fpu_gnt_i     (fpu_gnt),
        .fpu_rvalid_i  (fpu_rvalid),
        .fpu_rdata_i   (fpu_rdata),
        .fpu_rflags_i  (fpu_rflags),
        .core_rvalid_o (core_rvalid),
        .core_rready_i (core_rready),
        .core_rdata_o  (core_rdata),
        .core_rflags_o (core_rflags),
        .outstanding_o (outstanding),
        .overflow_o    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        core_req    = 1'b0;
        fpu_gnt     = 1'b0;
        fpu_rvalid  = 1'b0;
        fpu_rdata   = '0;
        fpu_rflags  = '0;
        core_rready = 1'b0;
    endtask

    task automatic test_reset;
        clear_inputs();
        rst_n = 1'b0;
        #12;
        n_vec++; if (core_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got=%0h exp=0", core_rvalid); end
        n_vec++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL reset_outstanding got=%0d exp=0", outstanding); end
        n_vec++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%0h exp=0", overflow); end
        n_vec++; if (core_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", core_rdata); end
        n_vec++; if ({core_gnt, fpu_req} !== 2'b00) begin n_fail++; $display("FAIL reset_gnt_req got=%b exp=00", {core_gnt, fpu_req}); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_op;
        core_req = 1'b1; fpu_gnt = 1'b1;
        #1;
        n_vec++; if ({fpu_req, core_gnt} !== 2'b11) begin n_fail++; $display("FAIL single_issue got=%b exp=11", {fpu_req, core_gnt}); end
        tick();
        core_req = 1'b0; fpu_gnt = 1'b0;
        #1;
        n_vec++; if (outstanding !== 3'd1) begin n_fail++; $display("FAIL single_out1 got=%0d exp=1", outstanding); end
        tick();
        tick();
        fpu_rvalid = 1'b1; fpu_rdata = 32'h3F80_0000; fpu_rflags = 5'h01;
        #1;
`ifdef FC_APU_RESP_BYPASS_EN
        n_vec++; if (core_rvalid !== 1'b1) begin n_fail++; $display("FAIL single_bypass_rvalid got=%0h exp=1", core_rvalid); end
`else
        n_vec++; if (core_rvalid !== 1'b0) begin n_fail++; $display("FAIL single_latency got=%0h exp=0", core_rvalid); end
`endif
        tick();
        fpu_rvalid = 1'b0; fpu_rdata = '0; fpu_rflags = '0;
        #1;
        n_vec++; if (core_rvalid !== 1'b1) begin n_fail++; $display("FAIL single_rvalid got=%0h exp=1", core_rvalid); end
        n_vec++; if (core_rdata !== 32'h3F80_0000) begin n_fail++; $display("FAIL single_rdata got=%h exp=3f800000", core_rdata); end
        n_vec++; if (core_rflags !== 5'h01) begin n_fail++; $display("FAIL single_rflags got=%h exp=01", core_rflags); end
        n_vec++; if (outstanding !== 3'd1) begin n_fail++; $display("FAIL single_out_held got=%0d exp=1", outstanding); end
        tick();
        n_vec++; if (core_rdata !== 32'h3F80_0000 || core_rvalid !== 1'b1) begin n_fail++; $display("FAIL single_stable got=%h/%0h exp=3f800000/1", core_rdata, core_rvalid); end
        core_rready = 1'b1;
        tick();
        core_rready = 1'b0;
        #1;
        n_vec++; if (core_rvalid !== 1'b0) begin n_fail++; $display("FAIL single_retired got=%0h exp=0", core_rvalid); end
        n_vec++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL single_out0 got=%0d exp=0", outstanding); end
    endtask

    task automatic test_credit_stall;
        core_req = 1'b1; fpu_gnt = 1'b1;
        repeat (4) tick();
        n_vec++; if (outstanding !== 3'd4) begin n_fail++; $display("FAIL stall_out4 got=%0d exp=4", outstanding); end
        n_vec++; if ({fpu_req, core_gnt} !== 2'b00) begin n_fail++; $display("FAIL stall_gated got=%b exp=00", {fpu_req, core_gnt}); end
        core_req = 1'b0; fpu_gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fpu_rvalid = 1'b1; fpu_rdata = 32'h10 + i; fpu_rflags = 5'(i);
            tick();
        end
        fpu_rvalid = 1'b0;
        #1;
        n_vec++; if (core_rdata !== 32'h10) begin n_fail++; $display("FAIL stall_head got=%h exp=10", core_rdata); end
        n_vec++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL stall_overflow got=%0h exp=0", overflow); end
        core_rready = 1'b1; core_req = 1'b1; fpu_gnt = 1'b1;
        #1;
        n_vec++; if (core_gnt !== 1'b0) begin n_fail++; $display("FAIL stall_gnt_pop_cycle got=%0h exp=0", core_gnt); end
        tick();
        core_rready = 1'b0;
        #1;
        n_vec++; if (outstanding !== 3'd3) begin n_fail++; $display("FAIL stall_out3 got=%0d exp=3", outstanding); end
        n_vec++; if ({fpu_req, core_gnt} !== 2'b11) begin n_fail++; $display("FAIL stall_resume got=%b exp=11", {fpu_req, core_gnt}); end
        n_vec++; if (core_rdata !== 32'h11) begin n_fail++; $display("FAIL stall_head2 got=%h exp=11", core_rdata); end
        tick();
        core_req = 1'b0; fpu_gnt = 1'b0;
        fpu_rvalid = 1'b1; fpu_rdata = 32'h14; fpu_rflags = 5'h4;
        tick();
        fpu_rvalid = 1'b0;
        #1;
        n_vec++; if (outstanding !== 3'd4) begin n_fail++; $display("FAIL stall_refill got=%0d exp=4", outstanding); end
    endtask

    // FIFO now holds 11,12,13,14.
    task automatic test_full_push_pop;
        fpu_rvalid = 1'b1; fpu_rdata = 32'h15; fpu_rflags = 5'h5; core_rready = 1'b1;
        #1;
        n_vec++; if (core_rdata !== 32'h11) begin n_fail++; $display("FAIL fpp_head got=%h exp=11", core_rdata); end
        tick();
        fpu_rvalid = 1'b0; core_rready = 1'b0;
        #1;
        n_vec++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fpp_overflow got=%0h exp=0", overflow); end
        n_vec++; if (core_rdata !== 32'h12) begin n_fail++; $display("FAIL fpp_head_next got=%h exp=12", core_rdata); end
        n_vec++; if (outstanding !== 3'd3) begin n_fail++; $display("FAIL fpp_out got=%0d exp=3", outstanding); end
    endtask

    // FIFO now holds 12,13,14,15 (full).
    task automatic test_overflow;
        fpu_rvalid = 1'b1; fpu_rdata = 32'h99; fpu_rflags = 5'h1F;
        tick();
        fpu_rvalid = 1'b0;
        #1;
        n_vec++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got=%0h exp=1", overflow); end
        tick();
        n_vec++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got=%0h exp=1", overflow); end
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (core_rvalid !== 1'b1 || core_rdata !== 32'h12 + i) begin n_fail++; $display("FAIL ovf_drain%0d got=%0h/%h exp=1/%h", i, core_rvalid, core_rdata, 32'h12 + i); end
            n_vec++; if (core_rflags !== 5'(2 + i)) begin n_fail++; $display("FAIL ovf_flags%0d got=%h exp=%h", i, core_rflags, 5'(2 + i)); end
            core_rready = 1'b1;
            tick();
            core_rready = 1'b0;
            #1;
        end
        n_vec++; if (core_rvalid !== 1'b0) begin n_fail++; $display("FAIL ovf_discarded got=%0h exp=0", core_rvalid); end
        n_vec++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky2 got=%0h exp=1", overflow); end
        // Reset mid-operation with an op in flight.
        core_req = 1'b1; fpu_gnt = 1'b1;
        tick();
        core_req = 1'b0; fpu_gnt = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        n_vec++; if ({overflow, outstanding} !== 4'b0000) begin n_fail++; $display("FAIL ovf_reset got=%b exp=0000", {overflow, outstanding}); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_ordering;
        int issued = 0;
        int returned = 0;
        int retired = 0;
        int cyc = 0;
        bit do_ret;
        while (retired < 8 && cyc < 200) begin
            do_ret      = (returned < issued);
            core_req    = (issued < 8);
            fpu_gnt     = 1'b1;
            fpu_rvalid  = do_ret;
            fpu_rdata   = 32'(returned);
            fpu_rflags  = 5'(returned);
            core_rready = 1'($urandom_range(0, 1));
            #1;
            if (core_rvalid && core_rready) begin
                n_vec++; if (core_rdata !== 32'(retired)) begin n_fail++; $display("FAIL order_data got=%h exp=%h", core_rdata, 32'(retired)); end
                retired++;
            end
            if (do_ret) returned++;
            if (fpu_req && fpu_gnt) issued++;
            tick();
            cyc++;
        end
        clear_inputs();
        #1;
        n_vec++; if (retired !== 8) begin n_fail++; $display("FAIL order_count got=%0d exp=8", retired); end
        n_vec++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL order_out got=%0d exp=0", outstanding); end
        n_vec++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL order_overflow got=%0h exp=0", overflow); end
    endtask

`ifdef FC_APU_RESP_BYPASS_EN
    task automatic test_bypass;
        core_req = 1'b1; fpu_gnt = 1'b1;
        tick();
        core_req = 1'b0; fpu_gnt = 1'b0;
        fpu_rvalid = 1'b1; fpu_rdata = 32'hDEAD_BEEF; fpu_rflags = 5'h1F; core_rready = 1'b1;
        #1;
        n_vec++; if (core_rvalid !== 1'b1) begin n_fail++; $display("FAIL bypass_rvalid got=%0h exp=1", core_rvalid); end
        n_vec++; if (core_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL bypass_rdata got=%h exp=deadbeef", core_rdata); end
        tick();
        clear_inputs();
        #1;
        n_vec++; if (core_rvalid !== 1'b0) begin n_fail++; $display("FAIL bypass_empty got=%0h exp=0", core_rvalid); end
        n_vec++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL bypass_out got=%0d exp=0", outstanding); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_op();
        test_credit_stall();
        test_full_push_pop();
        test_overflow();
        test_ordering();
`ifdef FC_APU_RESP_BYPASS_EN
        test_bypass();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
